// File: rtl/cache_pkg.sv
// Purpose: shared geometry, state encoding and address helpers for the data cache.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cache_pkg;

    // Default geometry; dcache_ctrl parameters take these as defaults and the
    // field widths below are derived from the same numbers.
    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_WIDTH = 32;

    localparam int WORD_BITS   = $clog2(DEF_LINE_WORDS);
    localparam int OFFSET_BITS = WORD_BITS + 2;
    localparam int INDEX_BITS  = $clog2(DEF_NUM_LINES);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    typedef logic [TAG_BITS-1:0]       tag_t;
    typedef logic [INDEX_BITS-1:0]     index_t;
    typedef logic [WORD_BITS-1:0]      word_sel_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

    function automatic word_sel_t addr_word(input addr_t addr);
        return addr[OFFSET_BITS-1:2];
    endfunction

    function automatic index_t addr_index(input addr_t addr);
        return addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    endfunction

    function automatic tag_t addr_tag(input addr_t addr);
        return addr[DEF_ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    endfunction

    // Word-aligned address of one beat of a line.
    function automatic addr_t beat_addr(input tag_t tag, input index_t index, input word_sel_t beat);
        return {tag, index, beat, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Purpose: tag/valid/dirty/data storage for the direct-mapped cache.
// Latency: combinational line read; word and metadata writes land on the next rising edge.
// Backpressure: none; the controller sequences all writes.
// Ports: index selects the line for both read and write; word_* writes one data word;
//        meta_* updates valid/dirty/tag; reset (active-low) clears valid and dirty only.
module dcache_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  index_t                       index,
    output logic                         line_valid,
    output logic                         line_dirty,
    output tag_t                         line_tag,
    output logic [LINE_WORDS-1:0][31:0]  line_data,
    input  logic                         word_we,
    input  word_sel_t                    word_sel,
    input  logic [31:0]                  word_data,
    input  logic                         meta_we,
    input  logic                         meta_valid,
    input  logic                         meta_dirty,
    input  tag_t                         meta_tag
);

    logic [NUM_LINES-1:0]            valid_bits;
    logic [NUM_LINES-1:0]            dirty_bits;
    tag_t                            tag_mem  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]     data_mem [NUM_LINES];

    assign line_valid = valid_bits[index];
    assign line_dirty = dirty_bits[index];
    assign line_tag   = tag_mem[index];
    assign line_data  = data_mem[index];

    // Only the state bits are reset; stale tags/data are harmless once valid is 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (meta_we) begin
            valid_bits[index] <= meta_valid;
            dirty_bits[index] <= meta_dirty;
        end
    end

    always_ff @(posedge clock) begin
        if (word_we) begin
            data_mem[index][word_sel] <= word_data;
        end
        if (meta_we) begin
            tag_mem[index] <= meta_tag;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Purpose: direct-mapped write-back write-allocate D-cache controller (FSM, hit logic, memory muxing).
// Latency: hits complete in the issuing cycle; misses take 1 + beats (x2 when the victim is dirty).
// Backpressure: cache_stall freezes the pipeline; each memory beat holds until mem_ack.
// Ports: cpu_* from/to the MEM stage; mem_* one-word beats to main memory; reset is async active-low.
module dcache_ctrl #(
    parameter int NUM_LINES  = cache_pkg::DEF_NUM_LINES,
    parameter int LINE_WORDS = cache_pkg::DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = cache_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read_en,
    input  logic                  cpu_write_en,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_write_data,
    output logic [31:0]           cpu_read_data,
    output logic                  cache_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);
    import cache_pkg::*;

    localparam word_sel_t LAST_BEAT = word_sel_t'(LINE_WORDS - 1);

    state_t    state, next_state;
    word_sel_t beat, next_beat;

    index_t    cpu_index;
    tag_t      cpu_tag;
    word_sel_t cpu_word;

    logic                        line_valid, line_dirty;
    tag_t                        line_tag;
    logic [LINE_WORDS-1:0][31:0] line_data;

    logic        word_we, meta_we, meta_valid, meta_dirty;
    word_sel_t   word_sel;
    logic [31:0] word_data;

    logic access, hit;

    assign cpu_index = addr_index(cpu_addr);
    assign cpu_tag   = addr_tag(cpu_addr);
    assign cpu_word  = addr_word(cpu_addr);

    assign access = cpu_read_en | cpu_write_en;
    assign hit    = line_valid && (line_tag == cpu_tag);

    // Outputs are masked by reset so the pipeline sees no stall while reset is held,
    // even with an access pending against the freshly invalidated array.
    assign cache_stall   = reset && access && ((state != IDLE) || !hit);
    assign cpu_read_data = (reset && hit) ? line_data[cpu_word] : 32'd0;

    dcache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .index      (cpu_index),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .word_we    (word_we),
        .word_sel   (word_sel),
        .word_data  (word_data),
        .meta_we    (meta_we),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty),
        .meta_tag   (cpu_tag)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= next_state;
            beat  <= next_beat;
        end
    end

    always_comb begin
        next_state = state;
        next_beat  = beat;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        word_we    = 1'b0;
        word_sel   = cpu_word;
        word_data  = cpu_write_data;
        meta_we    = 1'b0;
        meta_valid = 1'b1;
        meta_dirty = 1'b1;

        unique case (state)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        // Write wins when both enables are set.
                        if (cpu_write_en) begin
                            word_we = 1'b1;
                            meta_we = 1'b1;
                        end
                    end else begin
                        next_beat  = '0;
                        next_state = (line_valid && line_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end

            WRITEBACK: begin
                // Victim shares the index; its tag is still in the array.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = beat_addr(line_tag, cpu_index, beat);
                mem_wdata = line_data[beat];
                if (mem_ack) begin
                    if (beat == LAST_BEAT) begin
                        next_beat  = '0;
                        next_state = REFILL;
                    end else begin
                        next_beat = beat + 1'b1;
                    end
                end
            end

            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = beat_addr(cpu_tag, cpu_index, beat);
                if (mem_ack) begin
                    word_we   = 1'b1;
                    word_sel  = beat;
                    word_data = mem_rdata;
                    if (beat == LAST_BEAT) begin
                        // Line becomes valid only once every word has arrived.
                        meta_we    = 1'b1;
                        meta_dirty = 1'b0;
                        next_beat  = '0;
                        next_state = IDLE;
                    end else begin
                        next_beat = beat + 1'b1;
                    end
                end
            end

            default: begin
                next_state = IDLE;
                next_beat  = '0;
            end
        endcase

        if (!reset) begin
            word_we = 1'b0;
            meta_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read_en = 1'b0;
    logic        cpu_write_en = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_write_data = 32'd0;
    logic [31:0] cpu_read_data;
    logic        cache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int mem_delay = 0;
    int wait_cnt = 0;
    logic stray_ack = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       beatq[$];
    logic [31:0] rdq[$];

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] shadow    [logic [31:0]];

    logic        m_valid [16];
    logic        m_dirty [16];
    logic [23:0] m_tag   [16];

    dcache_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_read_en    (cpu_read_en),
        .cpu_write_en   (cpu_write_en),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cache_stall    (cache_stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_word(a);
    endfunction

    // Architectural value the CPU should observe at a word address.
    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : mem_rd(a);
    endfunction

    // Memory model: every cycle with a request is compared against the expected
    // beat at the head of the queue, so fields must stay stable through waits.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            checks++;
            assert (beatq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat: got addr %h we %b expected no request", mem_addr, mem_we);
            end
            if (beatq.size() != 0) begin
                check("beat_we", 32'(mem_we), 32'(beatq[0].we));
                check("beat_addr", mem_addr, beatq[0].addr);
                if (beatq[0].we) check("beat_wdata", mem_wdata, beatq[0].data);
            end
            if (wait_cnt == mem_delay) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = mem_rd(mem_addr);
                if (beatq.size() != 0) void'(beatq.pop_front());
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    task automatic model_reset();
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                for (int w = 0; w < 4; w++) begin
                    a = {m_tag[i], 4'(i), 2'(w), 2'b00};
                    shadow.delete(a);
                end
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        beatq.delete();
        rdq.delete();
    endtask

    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] a;
        logic [3:0]  idx;
        logic [23:0] t;
        logic [31:0] va;
        int          exp_stall;
        int          stalls;
        int          per;
        bit          done;
        a         = {addr[31:2], 2'b00};
        idx       = a[7:4];
        t         = a[31:8];
        exp_stall = 0;
        stalls    = 0;
        per       = mem_delay + 1;
        done      = 1'b0;
        if (!(m_valid[idx] && m_tag[idx] == t)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    va = {m_tag[idx], idx, 2'(w), 2'b00};
                    beatq.push_back('{1'b1, va, arch_rd(va)});
                end
                exp_stall += 4 * per;
            end
            for (int w = 0; w < 4; w++) begin
                va = {t, idx, 2'(w), 2'b00};
                beatq.push_back('{1'b0, va, 32'd0});
            end
            exp_stall += 4 * per + 1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = t;
        end
        if (wr) begin
            shadow[a]    = wdata;
            m_dirty[idx] = 1'b1;
        end else if (rd) begin
            rdq.push_back(arch_rd(a));
        end

        @(posedge clock); #1;
        cpu_read_en    = rd;
        cpu_write_en   = wr;
        cpu_addr       = addr;
        cpu_write_data = wdata;
        while (!done) begin
            @(negedge clock);
            if (!cache_stall || stalls >= 400) done = 1'b1;
            else begin
                stalls++;
                @(posedge clock);
            end
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_mem_req_done"}, 32'(mem_req), 32'd0);
        check({tag, "_beats_left"}, 32'(beatq.size()), 32'd0);
        if (rd && !wr && rdq.size() != 0) check({tag, "_rdata"}, cpu_read_data, rdq.pop_front());
        @(posedge clock); #1;
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 24'd0;
        end

        // Reset state, with a load already pending.
        cpu_read_en = 1'b1;
        cpu_addr    = 32'h40;
        @(negedge clock);
        check("rst_stall", 32'(cache_stall), 32'd0);
        check("rst_rdata", cpu_read_data, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clock); #1;
        cpu_read_en = 1'b0;
        reset       = 1'b1;

        // Idle: no traffic, no stall.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("idle_mem_req", 32'(mem_req), 32'd0);
            check("idle_stall", 32'(cache_stall), 32'd0);
        end

        do_access("cold_rd",     1'b1, 1'b0, 32'h0000_0040, 32'd0);
        do_access("rd_hit",      1'b1, 1'b0, 32'h0000_0048, 32'd0);
        do_access("wr_hit",      1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        do_access("rd_after_wr", 1'b1, 1'b0, 32'h0000_0044, 32'd0);
        do_access("dirty_evict", 1'b1, 1'b0, 32'h0000_0140, 32'd0);
        do_access("refetch",     1'b1, 1'b0, 32'h0000_0044, 32'd0);

        // Reset during refill, after the second beat has been acknowledged.
        for (int w = 0; w < 4; w++) beatq.push_back('{1'b0, 32'h200 + 32'(w * 4), 32'd0});
        @(posedge clock); #1;
        cpu_read_en = 1'b1;
        cpu_addr    = 32'h0000_0200;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_stall", 32'(cache_stall), 32'd0);
        check("midrst_beats_done", 32'(beatq.size()), 32'd2);
        cpu_read_en = 1'b0;
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;

        do_access("post_reset_rd", 1'b1, 1'b0, 32'h0000_0200, 32'd0);
        do_access("wr_204",        1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D);
        mem_delay = 3;
        do_access("slow_evict",    1'b1, 1'b0, 32'h0000_0300, 32'd0);
        mem_delay = 0;
        do_access("slow_back",     1'b1, 1'b0, 32'h0000_0204, 32'd0);
        do_access("rw_both",       1'b1, 1'b1, 32'h0000_020C, 32'h1357_2468);
        do_access("rd_20c",        1'b1, 1'b0, 32'h0000_020C, 32'd0);

        // Stray acks with no request must not disturb anything.
        stray_ack = 1'b1;
        repeat (3) @(posedge clock);
        stray_ack = 1'b0;
        do_access("rd_20c_again",  1'b1, 1'b0, 32'h0000_020C, 32'd0);

        do_access("wr_miss",       1'b0, 1'b1, 32'h0000_0408, 32'h0BAD_F00D);
        do_access("rd_408",        1'b1, 1'b0, 32'h0000_0408, 32'd0);
        do_access("rd_40c",        1'b1, 1'b0, 32'h0000_040C, 32'd0);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
